maze_player: RTL and testbench
==============================

MAZE_PLAYER -- requirements
Module: maze_player

Interface
REQ-001 Parameter COLS, default 10, maze width in cells.
REQ-002 Parameter ROWS, default 15, maze height in cells.
REQ-003 Parameter COOLDOWN, default 4, idle cycles after each accepted move; 0 allowed.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 h_walls  in  COLS*ROWS+COLS (160)  horizontal walls; bit y*COLS+x = north wall of cell (x,y); bit (y+1)*COLS+x = south wall.
REQ-007 v_walls  in  (COLS+1)*ROWS (165)  vertical walls; bit y*(COLS+1)+x = west wall of (x,y); bit y*(COLS+1)+x+1 = east wall.
REQ-008 maze_busy  in  1  generator busy; walls are valid only while low.
REQ-009 move_valid  in  1  move request present.
REQ-010 move_dir  in  2  0=North(y-1), 1=East(x+1), 2=South(y+1), 3=West(x-1).
REQ-011 move_ready  out  1  high only in IDLE.
REQ-012 player_x  out  4  current column.
REQ-013 player_y  out  4  current row.
REQ-014 moves  out  10  count of successful moves, saturating at 1023.
REQ-015 blocked  out  1  one-cycle pulse when an accepted move hits a wall or the grid edge.
REQ-016 won  out  1  high while the player is at the exit (COLS-1,ROWS-1).

Function
REQ-017 States: WAIT_GEN, IDLE, COOL, WON; all outputs registered.
REQ-018 WAIT_GEN: set internal flag armed on any cycle with maze_busy=1; go to IDLE on the first cycle with armed=1 and maze_busy=0; clear armed on exit.
REQ-019 Handshake: a move is accepted on an edge where move_valid=1 and move_ready=1; move_dir is sampled on that same edge.
REQ-020 Accepted move is passable iff target cell is in range and the separating wall bit is 0.
REQ-021 Passable: on the accept edge, update player_x/player_y and increment moves (saturating); results are visible the cycle after accept (latency 1).
REQ-022 Not passable: position and moves unchanged; blocked=1 for exactly the next cycle.
REQ-023 After any accept, go to COOL for COOLDOWN cycles, then IDLE; with COOLDOWN=0, go directly to IDLE (back-to-back accepts possible).
REQ-024 Move into (COLS-1,ROWS-1): go to WON instead of COOL; won=1 and move_ready=0 until rst or regeneration.
REQ-025 Edge checks do not rely on outer wall bits: North at y=0, West at x=0, East at x=COLS-1, South at y=ROWS-1 are always blocked.
REQ-026 Regeneration: maze_busy=1 in IDLE, COOL or WON enters WAIT_GEN with armed=1, player to (0,0), moves=0, won=0; this takes priority over a simultaneous accept.
REQ-027 move_valid is ignored outside IDLE; requests are not queued.
REQ-028 The cooldown counter is ceil(log2(COOLDOWN+1)) bits wide (minimum 1) and is reloaded on every accept.

Reset
REQ-029 rst: state=WAIT_GEN, armed=0, player_x=0, player_y=0, moves=0, blocked=0, won=0, move_ready=0, cooldown counter=0.
REQ-030 rst mid-move or mid-cooldown discards the pending move; rst overrides every other input.

Structure
REQ-031 Shared package maze_pkg holds COLS, ROWS, the direction encoding, the state encoding and the wall-index helper constants; the package is shared with maze_generator.
REQ-032 One combinational sub-module, maze_wall_lookup, maps (x, y, dir, h_walls, v_walls) to passable; the FSM and counters stay in maze_player.

Verification
REQ-033 Scenario 1, start-up: rst, maze_busy 1 for 300 cycles then 0 -> move_ready rises exactly 1 cycle after maze_busy falls; player=(0,0); moves=0.
REQ-034 Scenario 2, open move: all walls 0, COOLDOWN=4, East accepted -> next cycle player=(1,0), moves=1; move_ready low 4 cycles, then high.
REQ-035 Scenario 3, walls and edges: v_walls[1]=1, East from (0,0) -> blocked 1-cycle pulse, position (0,0), moves 0; North at y=0 with h_walls[0]=0 -> blocked.
REQ-036 Scenario 4, win: carve a path and drive moves to (9,14) -> won=1, move_ready=0; further move_valid is ignored.
REQ-037 Scenario 5, regeneration and saturation: maze_busy pulse while in WON -> player (0,0), moves 0, won 0, then IDLE after maze_busy falls; COOLDOWN=0 with 1100 E/W moves -> moves holds at 1023.
REQ-038 Scenario 6, rst mid-cooldown: assert rst in COOL -> all outputs return to their reset values next cycle and state=WAIT_GEN.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze definitions: grid size, direction and player-state encodings, wall indexing.
package maze_pkg;

    localparam int unsigned COLS    = 10;
    localparam int unsigned ROWS    = 15;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned MOVES_W = 10;

    // Row strides of the flattened wall vectors
    localparam int unsigned H_STRIDE = COLS;
    localparam int unsigned V_STRIDE = COLS + 1;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_WAIT_GEN = 2'd0,
        ST_IDLE     = 2'd1,
        ST_COOL     = 2'd2,
        ST_WON      = 2'd3
    } state_e;

endpackage

// File: rtl/maze_wall_lookup.sv
// Combinational passability check for one step from (x,y) in direction dir.
module maze_wall_lookup
    import maze_pkg::*;
#(
    parameter int unsigned COLS = maze_pkg::COLS,
    parameter int unsigned ROWS = maze_pkg::ROWS,
    localparam int unsigned H_W  = COLS * ROWS + COLS,
    localparam int unsigned V_W  = (COLS + 1) * ROWS,
    localparam int unsigned HI_W = $clog2(H_W),
    localparam int unsigned VI_W = $clog2(V_W)
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  dir_e               dir_i,
    input  logic [H_W-1:0]     h_walls_i,
    input  logic [V_W-1:0]     v_walls_i,
    output logic               passable_c
);

    logic wall_n;
    logic wall_s;
    logic wall_w;
    logic wall_e;

    // Grid edges are decided from coordinates alone; outer wall bits are never trusted
    always_comb begin
        int unsigned xu;
        int unsigned yu;
        xu = 32'(x_i);
        yu = 32'(y_i);
        wall_n = h_walls_i[HI_W'(yu * COLS + xu)];
        wall_s = h_walls_i[HI_W'((yu + 1) * COLS + xu)];
        wall_w = v_walls_i[VI_W'(yu * (COLS + 1) + xu)];
        wall_e = v_walls_i[VI_W'(yu * (COLS + 1) + xu + 1)];
        passable_c = 1'b0;
        case (dir_i)
            DIR_N: passable_c = (y_i != '0) && !wall_n;
            DIR_E: passable_c = (x_i != COORD_W'(COLS - 1)) && !wall_e;
            DIR_S: passable_c = (y_i != COORD_W'(ROWS - 1)) && !wall_s;
            DIR_W: passable_c = (x_i != '0) && !wall_w;
            default: passable_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/maze_player.sv
// Player controller: waits for a generated maze, accepts moves, enforces cooldown and detects the exit.
module maze_player
    import maze_pkg::*;
#(
    parameter int unsigned COLS     = maze_pkg::COLS,
    parameter int unsigned ROWS     = maze_pkg::ROWS,
    parameter int unsigned COOLDOWN = 4,
    localparam int unsigned H_W   = COLS * ROWS + COLS,
    localparam int unsigned V_W   = (COLS + 1) * ROWS,
    localparam int unsigned CNT_W = (COOLDOWN == 0) ? 1 : $clog2(COOLDOWN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [H_W-1:0]     h_walls,
    input  logic [V_W-1:0]     v_walls,
    input  logic               maze_busy,
    input  logic               move_valid,
    input  logic [1:0]         move_dir,
    output logic               move_ready,
    output logic [COORD_W-1:0] player_x,
    output logic [COORD_W-1:0] player_y,
    output logic [MOVES_W-1:0] moves,
    output logic               blocked,
    output logic               won
);

    state_e             state_q, state_d;
    logic               armed_q, armed_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [MOVES_W-1:0] moves_q, moves_d;
    logic               blocked_q, blocked_d;
    logic               ready_q, ready_d;
    logic               won_q, won_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] tgt_x, tgt_y;
    logic               passable;

    maze_wall_lookup #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_lookup (
        .x_i        (x_q),
        .y_i        (y_q),
        .dir_i      (dir_e'(move_dir)),
        .h_walls_i  (h_walls),
        .v_walls_i  (v_walls),
        .passable_c (passable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_WAIT_GEN;
            armed_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            moves_q   <= '0;
            blocked_q <= 1'b0;
            ready_q   <= 1'b0;
            won_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            x_q       <= x_d;
            y_q       <= y_d;
            moves_q   <= moves_d;
            blocked_q <= blocked_d;
            ready_q   <= ready_d;
            won_q     <= won_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        x_d       = x_q;
        y_d       = y_q;
        moves_d   = moves_q;
        blocked_d = 1'b0;
        cnt_d     = cnt_q;
        tgt_x     = x_q;
        tgt_y     = y_q;

        case (dir_e'(move_dir))
            DIR_N: tgt_y = y_q - COORD_W'(1);
            DIR_E: tgt_x = x_q + COORD_W'(1);
            DIR_S: tgt_y = y_q + COORD_W'(1);
            DIR_W: tgt_x = x_q - COORD_W'(1);
            default: ;
        endcase

        case (state_q)
            ST_WAIT_GEN: begin
                if (maze_busy) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (move_valid) begin
                    cnt_d = CNT_W'(COOLDOWN);
                    if (passable) begin
                        x_d = tgt_x;
                        y_d = tgt_y;
                        if (moves_q != '1) moves_d = moves_q + MOVES_W'(1);
                    end else begin
                        blocked_d = 1'b1;
                    end
                    if (passable && tgt_x == COORD_W'(COLS - 1) && tgt_y == COORD_W'(ROWS - 1))
                        state_d = ST_WON;
                    else if (COOLDOWN != 0)
                        state_d = ST_COOL;
                end
            end
            ST_COOL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
            end
            ST_WON: ;
            default: state_d = ST_WAIT_GEN;
        endcase

        // Regeneration wins over any move accepted on the same edge
        if (maze_busy && state_q != ST_WAIT_GEN) begin
            state_d   = ST_WAIT_GEN;
            armed_d   = 1'b1;
            x_d       = '0;
            y_d       = '0;
            moves_d   = '0;
            blocked_d = 1'b0;
            cnt_d     = '0;
        end

        ready_d = (state_d == ST_IDLE);
        won_d   = (state_d == ST_WON);
    end

    assign move_ready = ready_q;
    assign player_x   = x_q;
    assign player_y   = y_q;
    assign moves      = moves_q;
    assign blocked    = blocked_q;
    assign won        = won_q;

endmodule

// File: tb/tb_maze_player.sv
// Scenario bench for maze_player: main instance with cooldown 4, second instance with cooldown 0.
module tb_maze_player;

    localparam int NC = 10;
    localparam int NR = 15;
    localparam int CD = 4;

    typedef struct {
        int x;
        int y;
        int mv;
        bit blk;
        bit win;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [159:0] hw;
    logic [164:0] vw;
    logic         busy;
    logic         mv, mv0;
    logic [1:0]   md, md0;
    logic         rdy, blk, wn, rdy0, blk0, wn0;
    logic [3:0]   px, py, px0, py0;
    logic [9:0]   mvs, mvs0;

    int total = 0;
    int bad   = 0;
    int mx = 0, my = 0, mm = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    maze_player #(.COLS(NC), .ROWS(NR), .COOLDOWN(CD)) dut (
        .clk(clk), .rst(rst), .h_walls(hw), .v_walls(vw), .maze_busy(busy),
        .move_valid(mv), .move_dir(md), .move_ready(rdy), .player_x(px),
        .player_y(py), .moves(mvs), .blocked(blk), .won(wn)
    );

    maze_player #(.COLS(NC), .ROWS(NR), .COOLDOWN(0)) dut0 (
        .clk(clk), .rst(rst), .h_walls(hw), .v_walls(vw), .maze_busy(busy),
        .move_valid(mv0), .move_dir(md0), .move_ready(rdy0), .player_x(px0),
        .player_y(py0), .moves(mvs0), .blocked(blk0), .won(wn0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_pass(int x, int y, int d);
        case (d)
            0: return (y > 0) && !hw[y*NC + x];
            1: return (x < NC-1) && !vw[y*(NC+1) + x + 1];
            2: return (y < NR-1) && !hw[(y+1)*NC + x];
            default: return (x > 0) && !vw[y*(NC+1) + x];
        endcase
    endfunction

    // Push the predicted outcome, perform one handshake, then check result and cooldown
    task automatic do_move(input int d, input string nm);
        exp_t e;
        int n;
        e.blk = !model_pass(mx, my, d);
        if (!e.blk) begin
            case (d)
                0: my = my - 1;
                1: mx = mx + 1;
                2: my = my + 1;
                default: mx = mx - 1;
            endcase
            if (mm < 1023) mm = mm + 1;
        end
        e.x = mx; e.y = my; e.mv = mm;
        e.win = (mx == NC-1) && (my == NR-1);
        sb.push_back(e);
        n = 0;
        while (!rdy && n < 50) begin tick(); n++; end
        if (!rdy) begin
            total++; bad++;
            $display("FAIL %s ready_timeout: move_ready=%0b want 1", nm, rdy);
        end
        mv = 1'b1; md = 2'(d);
        tick();
        mv = 1'b0;
        e = sb.pop_front();
        total++; if (px !== 4'(e.x)) begin bad++; $display("FAIL %s x: got %0d want %0d", nm, px, e.x); end
        total++; if (py !== 4'(e.y)) begin bad++; $display("FAIL %s y: got %0d want %0d", nm, py, e.y); end
        total++; if (mvs !== 10'(e.mv)) begin bad++; $display("FAIL %s moves: got %0d want %0d", nm, mvs, e.mv); end
        total++; if (blk !== e.blk) begin bad++; $display("FAIL %s blocked: got %0b want %0b", nm, blk, e.blk); end
        total++; if (wn !== e.win) begin bad++; $display("FAIL %s won: got %0b want %0b", nm, wn, e.win); end
        if (e.win) begin
            total++; if (rdy !== 1'b0) begin bad++; $display("FAIL %s ready_in_won: got %0b want 0", nm, rdy); end
        end else begin
            tick();
            total++; if (blk !== 1'b0) begin bad++; $display("FAIL %s blocked_pulse: got %0b want 0", nm, blk); end
            n = 1;
            while (!rdy && n < 20) begin tick(); n++; end
            total++; if (n != CD) begin bad++; $display("FAIL %s cooldown_len: got %0d want %0d", nm, n, CD); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; busy = 1'b0; mv = 1'b0; mv0 = 1'b0; md = '0; md0 = '0;
        hw = '0; vw = '0;
        repeat (2) tick();
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", rdy); end
        total++; if (px !== 4'd0 || py !== 4'd0) begin bad++; $display("FAIL reset_pos: got (%0d,%0d) want (0,0)", px, py); end
        total++; if (mvs !== 10'd0) begin bad++; $display("FAIL reset_moves: got %0d want 0", mvs); end
        total++; if (blk !== 1'b0 || wn !== 1'b0) begin bad++; $display("FAIL reset_flags: got blk=%0b won=%0b want 0 0", blk, wn); end
        rst = 1'b0;
    endtask

    task automatic test_startup();
        busy = 1'b1;
        repeat (300) tick();
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL startup_busy_ready: got %0b want 0", rdy); end
        busy = 1'b0;
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL startup_early_ready: got %0b want 0", rdy); end
        tick();
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL startup_ready: got %0b want 1", rdy); end
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL startup_ready0: got %0b want 1", rdy0); end
        total++; if (px !== 4'd0 || py !== 4'd0 || mvs !== 10'd0) begin
            bad++; $display("FAIL startup_state: got (%0d,%0d) moves=%0d want (0,0) 0", px, py, mvs);
        end
    endtask

    task automatic test_open_move();
        do_move(1, "open_east");
    endtask

    task automatic test_walls_edges();
        do_move(3, "back_west");
        vw[1] = 1'b1;
        do_move(1, "wall_east");
        hw[10] = 1'b1;
        do_move(2, "wall_south");
        do_move(0, "edge_north");
        do_move(3, "edge_west");
        hw = '0; vw = '0;
    endtask

    task automatic test_win();
        hw = '1; vw = '1;
        for (int x = 0; x < NC-1; x++) vw[x + 1] = 1'b0;
        for (int y = 0; y < NR-1; y++) hw[(y+1)*NC + NC-1] = 1'b0;
        vw[NC] = 1'b0;
        for (int i = 0; i < NC-1; i++) do_move(1, "carve_east");
        do_move(1, "edge_east");
        for (int i = 0; i < NR-1; i++) do_move(2, "carve_south");
        mv = 1'b1; md = 2'd0;
        repeat (6) tick();
        mv = 1'b0;
        total++; if (px !== 4'd9 || py !== 4'd14 || mvs !== 10'd25) begin
            bad++; $display("FAIL won_ignore: got (%0d,%0d) moves=%0d want (9,14) 25", px, py, mvs);
        end
        total++; if (wn !== 1'b1 || rdy !== 1'b0) begin bad++; $display("FAIL won_hold: got won=%0b ready=%0b want 1 0", wn, rdy); end
    endtask

    task automatic test_regen();
        busy = 1'b1;
        tick();
        total++; if (px !== 4'd0 || py !== 4'd0 || mvs !== 10'd0 || wn !== 1'b0 || rdy !== 1'b0) begin
            bad++; $display("FAIL regen_clear: got (%0d,%0d) moves=%0d won=%0b ready=%0b want (0,0) 0 0 0", px, py, mvs, wn, rdy);
        end
        hw = '0; vw = '0;
        repeat (2) tick();
        busy = 1'b0;
        tick();
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL regen_ready: got %0b want 1", rdy); end
        mx = 0; my = 0; mm = 0;
    endtask

    task automatic test_back_to_back_saturation();
        exp_t e;
        bit chk;
        for (int i = 0; i < 1100; i++) begin
            chk = (i == 0) || (i >= 1021 && i <= 1023) || (i == 1099);
            if (chk) begin
                e.x = (i % 2 == 0) ? 1 : 0; e.y = 0;
                e.mv = (i + 1 > 1023) ? 1023 : i + 1;
                e.blk = 1'b0; e.win = 1'b0;
                sb.push_back(e);
            end
            mv0 = 1'b1; md0 = (i % 2 == 0) ? 2'd1 : 2'd3;
            tick();
            if (chk) begin
                e = sb.pop_front();
                total++; if (mvs0 !== 10'(e.mv)) begin bad++; $display("FAIL sat_moves[%0d]: got %0d want %0d", i, mvs0, e.mv); end
                total++; if (px0 !== 4'(e.x)) begin bad++; $display("FAIL sat_x[%0d]: got %0d want %0d", i, px0, e.x); end
            end
        end
        mv0 = 1'b0;
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL sat_ready: got %0b want 1", rdy0); end
    endtask

    task automatic test_rst_cool();
        mv = 1'b1; md = 2'd1;
        tick();
        mv = 1'b0;
        tick();
        total++; if (px !== 4'd1 || rdy !== 1'b0) begin bad++; $display("FAIL rst_cool_pre: got x=%0d ready=%0b want 1 0", px, rdy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (px !== 4'd0 || py !== 4'd0 || mvs !== 10'd0 || rdy !== 1'b0 || blk !== 1'b0 || wn !== 1'b0) begin
            bad++; $display("FAIL rst_cool_outputs: got (%0d,%0d) moves=%0d ready=%0b blk=%0b won=%0b want all 0", px, py, mvs, rdy, blk, wn);
        end
        repeat (5) tick();
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rst_cool_unarmed: got %0b want 0", rdy); end
        busy = 1'b1;
        tick();
        busy = 1'b0;
        tick();
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rst_cool_rearm: got %0b want 1", rdy); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_open_move();
        test_walls_edges();
        test_win();
        test_regen();
        test_back_to_back_saturation();
        test_rst_cool();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
